// File: rtl/tff_seq_pkg.sv
// Shared types and constants for the T-flip-flop bank sequencer.
// Holds the controller state encoding and the default bank width.
package tff_seq_pkg;

    localparam int STATE_W       = 1;
    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: q toggles on a rising edge when t is high.
// Synchronous active-high reset clears q.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_bank_sequencer.sv
// Programmable counter built from a bank of T flip-flops; this block computes
// the toggle vector and runs the IDLE/RUN controller. Optional down-count: TFF_SEQ_DOWN_EN.
module tff_bank_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             auto_reload,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] start_val;
    logic             capture;
    logic             done_nxt;
    logic [WIDTH-1:0] step_up;
    logic [WIDTH-1:0] step_dn;
    logic [WIDTH-1:0] step;

    // Bank of T flip-flops; the only way to change count is through t_vec
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (count[i])
        );
    end

    // Bit i toggles once every lower bit is 1 (up) or 0 (down)
    always_comb begin
        logic carry;
        logic borrow;
        step_up = '0;
        step_dn = '0;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            step_up[i] = carry;
            step_dn[i] = borrow;
            carry      = carry & count[i];
            borrow     = borrow & ~count[i];
        end
    end

`ifdef TFF_SEQ_DOWN_EN
    assign step = dir ? step_dn : step_up;
`else
    logic unused_dir;
    assign unused_dir = dir ^ (|step_dn);
    assign step       = step_up;
`endif

    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        capture   = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    t_vec = count ^ load_val;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    capture   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (count == limit) begin
                    done_nxt = 1'b1;
                    if (auto_reload) begin
                        t_vec = count ^ start_val;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    t_vec = step;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            start_val <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (capture) begin
                start_val <= count;
            end
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Scoreboard bench for tff_bank_sequencer: directed scenarios plus random traffic
// against an arithmetic reference model of the counter.
module tb_tff_bank_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, stop, load, auto_reload, dir;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] count, t_vec;
    logic         busy, done;

    tff_bank_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .load        (load),
        .load_val    (load_val),
        .limit       (limit),
        .auto_reload (auto_reload),
        .dir         (dir),
        .count       (count),
        .t_vec       (t_vec),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           chk_t;
        logic [W-1:0] tv;
        logic [W-1:0] cnt;
        logic         bsy;
        logic         dn;
    } exp_t;

    exp_t q[$];
    int   nchecks = 0;
    int   nerr    = 0;

    // Reference model state
    bit m_run = 0;
    int m_cnt = 0;
    int m_sv  = 0;

    task automatic drv(input bit r, input bit st, input bit sp, input bit ld,
                       input int lv, input int lim, input bit ar, input bit d);
        exp_t e;
        int   cur;
        @(negedge clk);
        rst = r; start = st; stop = sp; load = ld;
        load_val = W'(lv); limit = W'(lim); auto_reload = ar; dir = d;
        cur  = m_cnt;
        e.dn = 1'b0;
        if (r) begin
            m_run = 0; m_cnt = 0; m_sv = 0;
        end else if (!m_run) begin
            if (ld) m_cnt = lv;
            else if (st) begin m_run = 1; m_sv = m_cnt; end
        end else begin
            if (sp) m_run = 0;
            else if (m_cnt == lim) begin
                e.dn = 1'b1;
                if (ar) m_cnt = m_sv;
                else m_run = 0;
            end else begin
`ifdef TFF_SEQ_DOWN_EN
                if (d) m_cnt = (m_cnt + 255) % 256;
                else   m_cnt = (m_cnt + 1) % 256;
`else
                m_cnt = (m_cnt + 1) % 256;
`endif
            end
        end
        e.chk_t = !r;
        e.tv    = W'(cur ^ m_cnt);
        e.cnt   = W'(m_cnt);
        e.bsy   = m_run;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input int lim, input bit ar);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, lim, ar, 0);
    endtask

    // Monitor: t_vec just after inputs settle, registered outputs after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_t) begin
                    nchecks++;
                    if (t_vec !== e.tv) begin
                        nerr++;
                        $display("FAIL tvec t=%0t got=%h exp=%h", $time, t_vec, e.tv);
                    end
                end
                @(posedge clk);
                #1;
                nchecks++;
                if (count !== e.cnt) begin
                    nerr++;
                    $display("FAIL count t=%0t got=%h exp=%h", $time, count, e.cnt);
                end
                nchecks++;
                if (busy !== e.bsy) begin
                    nerr++;
                    $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.bsy);
                end
                nchecks++;
                if (done !== e.dn) begin
                    nerr++;
                    $display("FAIL done t=%0t got=%b exp=%b", $time, done, e.dn);
                end
            end
        end
    end

    initial begin
        rst = 1; start = 0; stop = 0; load = 0; auto_reload = 0; dir = 0;
        load_val = '0; limit = '0;
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);
        // load A5
        drv(0, 0, 0, 1, 'hA5, 0, 0, 0);
        idle(2, 0, 0);
        // count 0..5, stop at limit
        drv(0, 0, 0, 1, 0, 5, 0, 0);
        drv(0, 1, 0, 0, 0, 5, 0, 0);
        idle(8, 5, 0);
        // wrap through zero
        drv(0, 0, 0, 1, 'hFE, 1, 0, 0);
        drv(0, 1, 0, 0, 0, 1, 0, 0);
        idle(6, 1, 0);
        // auto-reload 3..6 then stop
        drv(0, 0, 0, 1, 3, 6, 1, 0);
        drv(0, 1, 0, 0, 0, 6, 1, 0);
        idle(10, 6, 1);
        drv(0, 0, 1, 0, 0, 6, 1, 0);
        idle(2, 6, 1);
        // stop and start together in RUN at count 3
        drv(0, 0, 0, 1, 0, 200, 0, 0);
        drv(0, 1, 0, 0, 0, 200, 0, 0);
        idle(3, 200, 0);
        drv(0, 1, 1, 1, 'h55, 200, 0, 0);
        idle(2, 200, 0);
        // limit equal to count at start
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3, 0, 0);
        // reset in the middle of a run
        drv(0, 1, 0, 0, 0, 100, 0, 0);
        idle(3, 100, 0);
        drv(1, 0, 0, 0, 0, 100, 0, 0);
        idle(2, 100, 0);
`ifdef TFF_SEQ_DOWN_EN
        drv(0, 0, 0, 1, 2, 'hFE, 0, 1);
        drv(0, 1, 0, 0, 0, 'hFE, 0, 1);
        for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 'hFE, 0, 1);
`endif
        // random traffic; limit often near the live count so terminal counts occur
        for (int i = 0; i < 3000; i++) begin
            bit r, st, sp, ld, ar, d;
            int lim;
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 3) == 0);
            sp  = ($urandom_range(0, 24) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            ar  = $urandom_range(0, 1);
            d   = $urandom_range(0, 1);
            lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : (m_cnt + int'($urandom_range(0, 6))) % 256;
            drv(r, st, sp, ld, int'($urandom_range(0, 255)), lim, ar, d);
        end
        repeat (3) @(negedge clk);
        nchecks++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
